control_sequencer: RTL

- Multi-cycle instruction sequencer that sits directly upstream of the CPU datapath.
- Owns the 6-bit program counter and the instruction register. Fetches 16-bit instructions from a combinational-read instruction ROM and decodes them.
- Drives the datapath control word (DR, SA, SB, FS, MB, MM, MD, MW, RW) and a constant.
- Consumes the datapath Z flag and BusA for branches and jumps. Stalls on data-memory ready for loads and stores.

---
 rtl/control_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/HALT sequencer: owns PC and IR, decodes 16-bit
// instructions into the datapath control word, and stalls LD/ST on mem_ready.
module control_sequencer #(
    parameter int              PC_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_main,
    input  logic            reset,
    input  logic [15:0]     instr,
    input  logic            Z,
    input  logic [15:0]     BusA,
    input  logic            mem_ready,
    output logic [PC_W-1:0] PC,
    output logic [3:0]      DR,
    output logic [3:0]      SA,
    output logic [3:0]      SB,
    output logic [3:0]      FS,
    output logic            MB,
    output logic            MM,
    output logic            MD,
    output logic            MW,
    output logic            RW,
    output logic [15:0]     ConstOut,
    output logic            halted
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [15:0]     ir, ir_nxt;
    logic [3:0]      op;
    logic            unused_busa;

    // Branch displacement is the DR field read as a signed 4-bit value.
    function automatic logic signed [PC_W-1:0] sext_off(input logic [3:0] f);
        return {{(PC_W-4){f[3]}}, f};
    endfunction

    assign op          = ir[15:12];
    assign unused_busa = ^BusA[15:PC_W];

    always_ff @(posedge clk_main) begin
        if (!reset) begin
            state <= FETCH;
            pc_q  <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir;
        FS        = 4'b0000;
        MB        = 1'b0;
        MM        = 1'b0;
        MD        = 1'b0;
        MW        = 1'b0;
        RW        = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                ir_nxt    = instr;
                pc_nxt    = pc_q + PC_W'(1);
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = FETCH;
                if (!op[3]) begin
                    FS = {1'b0, op[2:0]};
                    RW = 1'b1;
                end else begin
                    case (op)
                        4'h8: begin
                            FS = 4'b0010;
                            MB = 1'b1;
                            RW = 1'b1;
                        end
                        4'h9: begin
                            MD        = 1'b1;
                            state_nxt = MEM;
                        end
                        4'hA: begin
                            MW        = 1'b1;
                            state_nxt = MEM;
                        end
                        // PC has already been incremented in FETCH, so the
                        // displacement is relative to the following instruction.
                        4'hB: if (Z) pc_nxt = pc_q + $unsigned(sext_off(ir[11:8]));
                        4'hC: pc_nxt = BusA[PC_W-1:0];
                        4'hF: state_nxt = HALT;
                        default: ;
                    endcase
                end
            end
            MEM: begin
                if (op == 4'h9) begin
                    MD = 1'b1;
                    RW = mem_ready;
                end else begin
                    MW = 1'b1;
                end
                if (mem_ready) state_nxt = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end

    assign PC       = pc_q;
    assign DR       = ir[11:8];
    assign SA       = ir[7:4];
    assign SB       = ir[3:0];
    assign ConstOut = {12'b0, ir[3:0]};

endmodule
